mp_regfile: RTL
===============

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter AW, default 5: address width; register count NREG = 2**AW.
REQ-003 Parameter NREAD, default 3: number of read ports.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 raddr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-007 rdata  out  NREAD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 rbusy  out  NREAD  scoreboard busy bit for raddr of port i.
REQ-009 we0, we1  in  1 each  write enables, write ports 0 and 1.
REQ-010 waddr0, waddr1  in  AW each  write addresses.
REQ-011 wdata0, wdata1  in  DATA_W each  write data.
REQ-012 set_busy  in  1  marks busy_addr as having a pending writer.
REQ-013 busy_addr  in  AW  register to mark busy.
REQ-014 ready  out  1  high when the clear sequence has finished and the file accepts operations.

Function
REQ-015 Register 0 SHALL always read as zero; writes and set_busy to address 0 SHALL be dropped.
REQ-016 Reads SHALL be combinational, with zero added latency, and independent per port.
REQ-017 A write SHALL update the array on the edge where we is high; the new value is visible on rdata from the next cycle.
REQ-018 When we0 and we1 target the same nonzero address in the same cycle, port 1 data SHALL be stored.
REQ-019 The clear state machine SHALL have two states, CLEAR and RUN, with an AW-bit counter cnt.
REQ-020 In CLEAR, each cycle SHALL write zero to register cnt and then increment cnt; after register NREG-1 is written, the state SHALL move to RUN.
REQ-021 ready SHALL be high only in RUN; with NREG=32, ready rises exactly 32 cycles after the first cycle with RST low.
REQ-022 While ready is low, rdata SHALL be all zero, rbusy all zero, and we0, we1 and set_busy ignored.
REQ-023 A busy bit SHALL set on the edge where set_busy is high for a nonzero busy_addr.
REQ-024 A busy bit SHALL clear on the edge where either write port writes its address.
REQ-025 When a set and a clear hit the same address in one cycle, set SHALL win (a new writer issued after writeback).
REQ-026 rbusy[i] SHALL equal the stored busy bit of raddr[i], subject to the bypass rule in REQ-030.

Reset
REQ-027 RST high at an edge SHALL force state CLEAR, cnt=0, ready=0 and all busy bits 0, regardless of current state.
REQ-028 RST asserted during CLEAR or RUN SHALL restart the clear from register 0; array contents are undefined until ready.

Configuration
REQ-029 Macro MP_REGFILE_BYPASS_EN selects write-to-read forwarding.
REQ-030 Defined: in a cycle where a write to raddr[i] is enabled, rdata[i] SHALL return that write's data (port 1 over port 0) and rbusy[i] SHALL read 0 unless set_busy hits the same address in that cycle. Address 0 is never forwarded, and forwarding is disabled while ready is low.
REQ-031 Undefined: rdata and rbusy SHALL reflect only the stored state; the written value appears the cycle after the write.

Verification
REQ-032 Pulse RST for 1 cycle, then hold low -> ready=0 for 32 cycles, then ready=1; all raddr read 0.
REQ-033 we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr port 0=5 -> rdata port 0=0xDEADBEEF. A write to address 0 of 0x1234 -> address 0 still reads 0.
REQ-034 Same cycle: we0 and we1 both to address 7, data 0x11 and 0x22 -> next cycle address 7 reads 0x22.
REQ-035 set_busy to address 3 -> rbusy=1 for raddr=3. Then in one cycle, we1 to 3 plus set_busy to 3 -> rbusy stays 1. A later write to 3 alone -> rbusy=0.
REQ-036 With MP_REGFILE_BYPASS_EN: raddr=9 while we0 writes 0xABCD to 9 -> rdata=0xABCD in the same cycle. Without the macro -> old value that cycle, 0xABCD the next.
REQ-037 RST pulsed 10 cycles into RUN with busy bit 4 set -> ready drops, rbusy=0, writes ignored, ready returns 32 cycles later, and all registers read 0.

Source files
------------

// File: rtl/mp_regfile_if.sv
// mp_regfile bus: read ports, two write ports, scoreboard set
// and the ready flag; master drives, slave is the register file.
interface mp_regfile_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 3
);
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    we0;
  logic                    we1;
  logic [AW-1:0]           waddr0;
  logic [AW-1:0]           waddr1;
  logic [DATA_W-1:0]       wdata0;
  logic [DATA_W-1:0]       wdata1;
  logic                    set_busy;
  logic [AW-1:0]           busy_addr;
  logic                    ready;

  modport master (
    output raddr, we0, we1, waddr0, waddr1,
    output wdata0, wdata1, set_busy, busy_addr,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  raddr, we0, we1, waddr0, waddr1,
    input  wdata0, wdata1, set_busy, busy_addr,
    output rdata, rbusy, ready
  );
endinterface

// File: rtl/mp_regfile.sv
// Multi-read, dual-write register file with busy scoreboard and
// post-reset clear sweep; MP_REGFILE_BYPASS_EN enables forwarding.
module mp_regfile #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 3
) (
  input logic         CLK,
  input logic         RST,
  mp_regfile_if.slave bus
);
  localparam int NREG = 2**AW;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_cnt;
  logic              w_ready;
  logic              w_clr;
  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;
  logic              w_we0;
  logic              w_we1;
  logic              w_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) r_cnt <= r_cnt + AW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CLEAR:
        if (r_cnt == AW'(NREG - 1))
          w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_clr   = 1'b0;
    unique case (r_state)
      S_CLEAR: w_clr   = 1'b1;
      S_RUN:   w_ready = 1'b1;
      default: w_clr   = 1'b1;
    endcase
  end

  // Register 0 is hardwired, so every write path drops it.
  assign w_we0 = w_ready && !RST && bus.we0
                 && (bus.waddr0 != '0);
  assign w_we1 = w_ready && !RST && bus.we1
                 && (bus.waddr1 != '0);
  assign w_set = w_ready && !RST && bus.set_busy
                 && (bus.busy_addr != '0);

  assign bus.ready = w_ready;

  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_we0) r_mem[bus.waddr0] <= bus.wdata0;
      if (w_we1) r_mem[bus.waddr1] <= bus.wdata1;
    end
  end

  // Set is applied last so a new writer beats a same-cycle writeback.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy <= '0;
    end else begin
      if (w_we0) r_busy[bus.waddr0] <= 1'b0;
      if (w_we1) r_busy[bus.waddr1] <= 1'b0;
      if (w_set) r_busy[bus.busy_addr] <= 1'b1;
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (w_ready && (bus.raddr[i*AW +: AW] != '0)) begin
        bus.rdata[i*DATA_W +: DATA_W] =
          r_mem[bus.raddr[i*AW +: AW]];
        bus.rbusy[i] = r_busy[bus.raddr[i*AW +: AW]];
`ifdef MP_REGFILE_BYPASS_EN
        if (w_we1 && (bus.waddr1 == bus.raddr[i*AW +: AW])) begin
          bus.rdata[i*DATA_W +: DATA_W] = bus.wdata1;
          bus.rbusy[i] = w_set
            && (bus.busy_addr == bus.raddr[i*AW +: AW]);
        end else if (w_we0
            && (bus.waddr0 == bus.raddr[i*AW +: AW])) begin
          bus.rdata[i*DATA_W +: DATA_W] = bus.wdata0;
          bus.rbusy[i] = w_set
            && (bus.busy_addr == bus.raddr[i*AW +: AW]);
        end
`endif
      end
    end
  end
endmodule
